// File: rtl/sysref_gen_pkg.sv
// Shared types and default widths for the SYSREF pulse generator.
package sysref_gen_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_BURST_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/sysref_edge_detect.sv
// Rising-edge detector for an already-synchronised sync input.
module sysref_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= 1'b0;
        else       prev_q <= sig_i;
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/sysref_generator.sv
// Periodic/burst SYSREF generator with optional sync_in alignment.
// Define SYSREF_ALIGN_CHECK_EN to build the sticky phase-mismatch checker.
module sysref_generator
    import sysref_gen_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               master_clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               align_en,
    input  logic               sync_in,
    output logic               user_sysref_adc,
    output logic               user_sysref_dac,
    output logic               busy,
    output logic [BURST_W-1:0] pulse_count,
    output logic               align_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hp_q, hp_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] pc_q, pc_d;
    logic               stop_pend_q, stop_pend_d;
    logic               adc_q, dac_q, busy_q;
    logic [CNT_W-1:0]   eff_hp;
    logic               burst_done;
    logic               sync_rise;

    sysref_edge_detect u_edge (
        .clk_i  (master_clock),
        .rst_i  (reset),
        .sig_i  (sync_in),
        .rise_o (sync_rise)
    );

    assign eff_hp     = (half_period == '0) ? CNT_W'(1) : half_period;
    assign burst_done = (burst_q != '0) && ((pc_q + BURST_W'(1)) == burst_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hp_d        = hp_q;
        burst_d     = burst_q;
        pc_d        = pc_q;
        stop_pend_d = stop_pend_q;
        case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous stop; a stop alone is ignored
                if (start) begin
                    hp_d        = eff_hp;
                    burst_d     = burst_len;
                    pc_d        = '0;
                    stop_pend_d = 1'b0;
                    cnt_d       = eff_hp - CNT_W'(1);
                    state_d     = align_en ? S_ARM : S_HIGH;
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (sync_rise) begin
                    cnt_d   = hp_q - CNT_W'(1);
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (stop) stop_pend_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = hp_q - CNT_W'(1);
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (stop) stop_pend_d = 1'b1;
                if (cnt_q == '0) begin
                    if (pc_q != '1) pc_d = pc_q + BURST_W'(1);
                    if (burst_done) begin
                        stop_pend_d = 1'b0;
                        state_d     = S_IDLE;
                    end else if (stop_pend_q || stop) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d   = hp_q - CNT_W'(1);
                        state_d = S_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                stop_pend_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hp_q        <= CNT_W'(1);
            burst_q     <= '0;
            pc_q        <= '0;
            stop_pend_q <= 1'b0;
            adc_q       <= 1'b0;
            dac_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hp_q        <= hp_d;
            burst_q     <= burst_d;
            pc_q        <= pc_d;
            stop_pend_q <= stop_pend_d;
            adc_q       <= (state_d == S_HIGH);
            dac_q       <= (state_d == S_HIGH);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign user_sysref_adc = adc_q;
    assign user_sysref_dac = dac_q;
    assign busy            = busy_q;
    assign pulse_count     = pc_q;

`ifdef SYSREF_ALIGN_CHECK_EN
    logic align_err_q;
    logic running;
    logic out_rises;

    assign running   = (state_q == S_HIGH) || (state_q == S_LOW) || (state_q == S_DRAIN);
    // an aligned sync edge is one that precedes our own output rise by exactly one cycle
    assign out_rises = (state_d == S_HIGH) && !adc_q;

    always_ff @(posedge master_clock) begin
        if (reset)
            align_err_q <= 1'b0;
        else if ((state_q == S_IDLE) && start)
            align_err_q <= 1'b0;
        else if (sync_rise && running && !out_rises)
            align_err_q <= 1'b1;
    end

    assign align_err = align_err_q;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: doc/sysref_generator.md
SYSREF_GENERATOR -- requirements
Module: sysref_generator

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the half-period counter and of half_period.
REQ-002 SHALL have parameter BURST_W, default 8: width of burst_len and pulse_count.
REQ-003 SHALL have port master_clock, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin generation.
REQ-006 SHALL have port stop, input, 1: one-cycle request to end generation gracefully.
REQ-007 SHALL have port half_period, input, CNT_W: high time and low time in cycles; latched on an accepted start.
REQ-008 SHALL have port burst_len, input, BURST_W: 0 = continuous, N = exactly N pulses; latched on an accepted start.
REQ-009 SHALL have port align_en, input, 1: when 1, the first pulse waits for a sync_in rising edge.
REQ-010 SHALL have port sync_in, input, 1: external SYSREF already registered into master_clock.
REQ-011 SHALL have ports user_sysref_adc and user_sysref_dac, output, 1 each: registered, bit-identical generated SYSREF.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port pulse_count, output, BURST_W: completed pulses since the last start; saturates at all-ones.
REQ-014 SHALL have port align_err, output, 1: sticky phase-mismatch flag.

Function
REQ-015 SHALL implement the FSM states IDLE, ARM, HIGH, LOW and DRAIN.
REQ-016 In IDLE, start SHALL latch the configuration, clear pulse_count, and go to ARM if align_en=1, otherwise to HIGH.
REQ-017 A half_period of 0 SHALL be latched as 1.
REQ-018 Outputs SHALL be 1 exactly while in HIGH; the first high cycle SHALL be the cycle after start is sampled.
REQ-019 In ARM, a sync_in rising edge (current 1, previous 0) sampled in cycle t SHALL enter HIGH, with the outputs high from t+1.
REQ-020 HIGH SHALL last exactly the latched half_period cycles and then go to LOW.
REQ-021 LOW SHALL last exactly half_period cycles; at its end pulse_count SHALL increment.
REQ-022 At the end of LOW, the FSM SHALL go to IDLE if the burst is complete or stop is pending, otherwise to HIGH.
REQ-023 stop in HIGH or LOW SHALL be held pending; the current pulse finishes in full (no runt), passing through DRAIN for one cycle before IDLE.
REQ-024 stop in ARM SHALL go to IDLE next cycle with no pulse; stop in IDLE SHALL be ignored.
REQ-025 start while busy SHALL be ignored; start and stop in the same IDLE cycle SHALL accept the start.
REQ-026 Configuration input changes while busy SHALL have no effect.

Reset
REQ-027 Reset SHALL force IDLE; user_sysref_adc=0, user_sysref_dac=0, busy=0, pulse_count=0, align_err=0 and the pending stop cleared, effective the cycle after reset is sampled, including mid-pulse.

Configuration
REQ-028 With SYSREF_ALIGN_CHECK_EN defined, each sync_in rising edge in HIGH/LOW/DRAIN SHALL set align_err unless the generated outputs rise in the next cycle.
REQ-029 With SYSREF_ALIGN_CHECK_EN defined, align_err SHALL be cleared on reset and on an accepted start.
REQ-030 Without SYSREF_ALIGN_CHECK_EN, align_err SHALL be tied to 0 and no check logic SHALL exist.

Structure
REQ-031 Package sysref_gen_pkg SHALL hold the FSM state enum and the default CNT_W and BURST_W constants.
REQ-032 The sync_in previous-value register and rising-edge detect SHALL be one sub-module, sysref_edge_detect; all other logic SHALL be in sysref_generator.

Verification
REQ-033 half_period=4, burst_len=0, align_en=0, start at cycle 10 -> outputs high 11-14, low 15-18, high again at 19; busy=1 from 11.
REQ-034 half_period=2, burst_len=3 -> exactly 3 pulses, pulse_count=3, busy falls after the 12th generated cycle.
REQ-035 align_en=1, start at cycle 5, sync_in rising sampled at cycle 20 -> outputs first rise at cycle 21, never earlier.
REQ-036 half_period=4, stop on the 2nd HIGH cycle -> full 4 high + 4 low, DRAIN, IDLE; pulse_count +1; half_period=0 -> 1-high/1-low toggling.
REQ-037 reset during HIGH -> outputs 0 and busy 0 next cycle; a start during busy leaves the period unchanged.
REQ-038 With the macro, half_period=4 and sync_in rising 1 cycle late -> align_err=1 and held until the next start; aligned sync_in -> align_err stays 0.
